// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Dynamic conditional-branch predictor: a table of 2-bit saturating counters
// indexed by the fetch PC (optionally XOR global history), a registered
// decode-stage copy of the prediction, and resolved/mispredict statistics.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   pc_f, inst_f      fetch-stage PC and instruction word
//   stall, flush_d    decode-stage hold / squash (flush_d wins)
//   upd_en            conditional branch resolved in execute this cycle
//   upd_idx           table index carried with the resolved branch
//   upd_taken         resolved direction
//   upd_mispredict    resolved direction differed from the prediction
//   pred_taken_f      combinational fetch-stage prediction
//   prediction        registered decode-stage prediction
//   pred_idx_d        registered table index, pipelined down to upd_idx
//   branch_d          decode-stage instruction is a conditional branch
//   branch_cnt        saturating resolved-branch count
//   mispred_cnt       saturating mispredict count
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned GSHARE     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc_f,
  input  logic [31:0]           inst_f,
  input  logic                  stall,
  input  logic                  flush_d,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic                  pred_taken_f,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_idx_d,
  output logic                  branch_d,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);

  localparam int unsigned DEPTH     = 1 << INDEX_BITS;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [1:0]            r_table [DEPTH];
  logic [INDEX_BITS-1:0] r_ghr;
  logic                  r_prediction;
  logic [INDEX_BITS-1:0] r_pred_idx_d;
  logic                  r_branch_d;
  logic [CNT_W-1:0]      r_branch_cnt;
  logic [CNT_W-1:0]      r_mispred_cnt;

  logic                  w_is_br_f;
  logic [INDEX_BITS-1:0] w_pc_idx;
  logic [INDEX_BITS-1:0] w_idx_f;
  logic [1:0]            w_upd_cur;
  logic [1:0]            w_upd_nxt;
  logic                  w_unused_ok;

  // Fetch-side decode and index formation
  assign w_is_br_f = (inst_f[6:0] == OP_BRANCH);
  assign w_pc_idx  = pc_f[INDEX_BITS+1:2];

  generate
    if (GSHARE != 0) begin : g_gshare
      assign w_idx_f = w_pc_idx ^ r_ghr;
    end else begin : g_pc_only
      assign w_idx_f = w_pc_idx;
    end
  endgenerate

  // Table read sees the pre-update value when the same entry trains this cycle
  assign pred_taken_f = w_is_br_f & r_table[w_idx_f][1];

  // Saturating next value for the entry being trained
  assign w_upd_cur = r_table[upd_idx];
  always_comb begin
    w_upd_nxt = w_upd_cur;
    if (upd_taken) begin
      if (w_upd_cur != 2'b11) w_upd_nxt = w_upd_cur + 2'(1);
    end else begin
      if (w_upd_cur != 2'b00) w_upd_nxt = w_upd_cur - 2'(1);
    end
  end

  // Counter table, reset to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_table[i] <= 2'b01;
    end else if (upd_en) begin
      r_table[upd_idx] <= w_upd_nxt;
    end
  end

  // Non-speculative global history, shifted only by resolved branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (upd_en) begin
      r_ghr <= {r_ghr[INDEX_BITS-2:0], upd_taken};
    end
  end

  // Decode-stage registers: flush beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prediction <= 1'b0;
      r_pred_idx_d <= '0;
      r_branch_d   <= 1'b0;
    end else if (flush_d) begin
      r_prediction <= 1'b0;
      r_pred_idx_d <= '0;
      r_branch_d   <= 1'b0;
    end else if (!stall) begin
      r_prediction <= pred_taken_f;
      r_pred_idx_d <= w_idx_f;
      r_branch_d   <= w_is_br_f;
    end
  end

  // Statistics, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_en) begin
      if (r_branch_cnt != {CNT_W{1'b1}})
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (upd_mispredict && (r_mispred_cnt != {CNT_W{1'b1}}))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign prediction  = r_prediction;
  assign pred_idx_d  = r_pred_idx_d;
  assign branch_d    = r_branch_d;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // Instruction and PC bits that play no part in prediction
  assign w_unused_ok = ^{inst_f[31:7], pc_f[31:INDEX_BITS+2], pc_f[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor. u_pc is the PC-indexed variant with
// 4-bit statistics; u_gs is the gshare variant with 16-bit statistics. Both
// share stimulus; expected values go through a queue and are popped at the
// point where the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int unsigned IB = 6;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0000_006F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc_f, inst_f;
  logic          stall, flush_d, upd_en, upd_taken, upd_mispredict;
  logic [IB-1:0] upd_idx;

  logic          p_pred_f, p_pred, p_br_d;
  logic [IB-1:0] p_idx_d;
  logic [3:0]    p_bcnt, p_mcnt;
  logic          g_pred_f, g_pred, g_br_d;
  logic [IB-1:0] g_idx_d;
  logic [15:0]   g_bcnt, g_mcnt;

  branch_predictor #(.INDEX_BITS(IB), .GSHARE(0), .CNT_W(4)) u_pc (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .inst_f(inst_f),
    .stall(stall), .flush_d(flush_d), .upd_en(upd_en), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .pred_taken_f(p_pred_f), .prediction(p_pred), .pred_idx_d(p_idx_d),
    .branch_d(p_br_d), .branch_cnt(p_bcnt), .mispred_cnt(p_mcnt)
  );

  branch_predictor #(.INDEX_BITS(IB), .GSHARE(1), .CNT_W(16)) u_gs (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .inst_f(inst_f),
    .stall(stall), .flush_d(flush_d), .upd_en(upd_en), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .pred_taken_f(g_pred_f), .prediction(g_pred), .pred_idx_d(g_idx_d),
    .branch_d(g_br_d), .branch_cnt(g_bcnt), .mispred_cnt(g_mcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_cmp(obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_f = '0; inst_f = '0; stall = 1'b0; flush_d = 1'b0;
    upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;

    // Reset state
    #3;
    chk("rst_prediction", 32'(p_pred), 32'h0);
    chk("rst_branch_d",   32'(p_br_d), 32'h0);
    chk("rst_pred_idx",   32'(p_idx_d), 32'h0);
    chk("rst_branch_cnt", 32'(p_bcnt), 32'h0);
    chk("rst_mispred",    32'(p_mcnt), 32'h0);
    tick();
    rst_n = 1'b1;

    // First BEQ lookup at 0x40: weakly not-taken
    pc_f = 32'h40; inst_f = BEQ;
    #1;
    chk("beq_pred_f_init", 32'(p_pred_f), 32'h0);
    push("beq_prediction", 32'h0);
    push("beq_branch_d",   32'h1);
    push("beq_pred_idx",   32'h10);
    tick();
    pop_cmp(32'(p_pred));
    pop_cmp(32'(p_br_d));
    pop_cmp(32'(p_idx_d));

    // Train taken twice; same-cycle lookup sees the old counter
    upd_en = 1'b1; upd_idx = 6'h10; upd_taken = 1'b1;
    #1;
    chk("same_cycle_old", 32'(p_pred_f), 32'h0);
    tick();
    chk("after_one_upd", 32'(p_pred_f), 32'h1);
    tick();
    upd_en = 1'b0;
    #1;
    chk("cnt11_pred_f", 32'(p_pred_f), 32'h1);
    chk("bcnt_2",       32'(p_bcnt), 32'h2);
    tick();
    chk("cnt11_prediction", 32'(p_pred), 32'h1);

    // One not-taken: 11 -> 10, still taken
    upd_en = 1'b1; upd_taken = 1'b0;
    tick();
    upd_en = 1'b0;
    #1;
    chk("cnt10_pred_f", 32'(p_pred_f), 32'h1);
    chk("bcnt_3",       32'(p_bcnt), 32'h3);

    // Back to 11, then non-branch opcodes never predict
    upd_en = 1'b1; upd_taken = 1'b1;
    tick();
    upd_en = 1'b0; inst_f = ADDI;
    #1;
    chk("addi_pred_f", 32'(p_pred_f), 32'h0);
    tick();
    chk("addi_branch_d",   32'(p_br_d), 32'h0);
    chk("addi_prediction", 32'(p_pred), 32'h0);
    inst_f = JAL;
    #1;
    chk("jal_pred_f", 32'(p_pred_f), 32'h0);

    // Stall holds, flush beats stall
    inst_f = BEQ;
    tick();
    chk("pre_stall_pred", 32'(p_pred), 32'h1);
    stall = 1'b1; inst_f = ADDI; pc_f = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pred", 32'(p_pred), 32'h1);
      chk("stall_hold_idx",  32'(p_idx_d), 32'h10);
    end
    flush_d = 1'b1;
    tick();
    chk("flush_pred",     32'(p_pred), 32'h0);
    chk("flush_idx",      32'(p_idx_d), 32'h0);
    chk("flush_branch_d", 32'(p_br_d), 32'h0);
    flush_d = 1'b0; stall = 1'b0;

    // Saturation at both ends on entry 0x20 (pc 0x80)
    inst_f = BEQ; upd_idx = 6'h20; upd_en = 1'b1; upd_taken = 1'b0;
    tick(); tick();
    upd_taken = 1'b1;
    tick(); tick();
    upd_en = 1'b0;
    #1;
    chk("sat_low_pred", 32'(p_pred_f), 32'h1);
    upd_en = 1'b1; upd_taken = 1'b1;
    tick(); tick();
    upd_taken = 1'b0;
    tick();
    upd_en = 1'b0;
    #1;
    chk("sat_high_pred", 32'(p_pred_f), 32'h1);
    upd_en = 1'b1;
    tick();
    upd_en = 1'b0;
    #1;
    chk("sat_high_down2", 32'(p_pred_f), 32'h0);
    chk("bcnt_12",        32'(p_bcnt), 32'd12);
    chk("mcnt_0",         32'(p_mcnt), 32'h0);

    // Statistics: mispredict without upd_en ignored, then saturate
    upd_mispredict = 1'b1;
    tick();
    chk("mis_no_en", 32'(p_mcnt), 32'h0);
    upd_en = 1'b1; upd_idx = 6'h30; upd_taken = 1'b0;
    repeat (5) tick();
    chk("mcnt_5",      32'(p_mcnt), 32'h5);
    chk("bcnt_sat_15", 32'(p_bcnt), 32'hF);
    repeat (15) tick();
    upd_en = 1'b0; upd_mispredict = 1'b0;
    #1;
    chk("mcnt_sat", 32'(p_mcnt), 32'hF);
    chk("bcnt_sat", 32'(p_bcnt), 32'hF);

    // Asynchronous reset between edges
    pc_f = 32'h40; inst_f = BEQ;
    #1;
    chk("pre_rst_pred_f", 32'(p_pred_f), 32'h1);
    tick();
    chk("pre_rst_pred", 32'(p_pred), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pred_f",   32'(p_pred_f), 32'h0);
    chk("async_pred",     32'(p_pred), 32'h0);
    chk("async_branch_d", 32'(p_br_d), 32'h0);
    chk("async_bcnt",     32'(p_bcnt), 32'h0);
    chk("async_mcnt",     32'(p_mcnt), 32'h0);
    chk("async_gs_bcnt",  32'(g_bcnt), 32'h0);
    tick();
    rst_n = 1'b1;

    // Gshare index follows resolved history; update cycle uses old ghr
    tick();
    chk("gs_idx_ghr0", 32'(g_idx_d), 32'h10);
    upd_en = 1'b1; upd_idx = 6'h00; upd_taken = 1'b1;
    tick();
    chk("gs_idx_old_ghr", 32'(g_idx_d), 32'h10);
    upd_taken = 1'b0;
    tick();
    chk("gs_idx_ghr1", 32'(g_idx_d), 32'h11);
    upd_en = 1'b0;
    tick();
    chk("gs_idx_ghr2", 32'(g_idx_d), 32'h12);
    chk("pc_idx_fixed", 32'(p_idx_d), 32'h10);
    chk("gs_bcnt_2",    32'(g_bcnt), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required finish before bound");
    $fatal(1, "timeout");
  end

endmodule
